// File: rtl/axis_fifo_pkt.sv
// rtl/axis_fifo_pkt.sv - single-clock AXI-Stream FIFO with occupancy, threshold flags and packet mode
// First-word-fall-through: m_tdata/m_tlast are a combinational read of the head entry.
module axis_fifo_pkt #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int PTR_WIDTH   = 4,
  parameter int PACKET_MODE = 0,
  parameter int AFULL_THR   = 12,
  parameter int AEMPTY_THR  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [PTR_WIDTH:0]    level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    pkt_count
);

  localparam logic [PTR_WIDTH:0] CNT_ONE    = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0] AFULL_LVL  = (PTR_WIDTH+1)'(AFULL_THR);
  localparam logic [PTR_WIDTH:0] AEMPTY_LVL = (PTR_WIDTH+1)'(AEMPTY_THR);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [PTR_WIDTH:0]  wr_ptr;
  logic [PTR_WIDTH:0]  rd_ptr;
  logic                empty;
  logic                full;
  logic                release_ok;
  logic                wr_en;
  logic                rd_en;
  logic                wr_last;
  logic                rd_last;

  // The extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
                 (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);

  // Packet mode holds output until a whole frame is stored; a full FIFO
  // releases anyway so an oversize frame streams cut-through instead of deadlocking.
  if (PACKET_MODE != 0) begin : g_pkt
    assign release_ok = (pkt_count != '0) || full;
  end else begin : g_plain
    assign release_ok = 1'b1;
  end

  assign s_tready = !full;
  assign m_tvalid = !empty && release_ok;

  assign wr_en   = s_tvalid && s_tready && !rst;
  assign rd_en   = m_tvalid && m_tready && !rst;
  assign wr_last = wr_en && s_tlast;
  assign rd_last = rd_en && m_tlast;

  assign {m_tlast, m_tdata} = mem[rd_ptr[PTR_WIDTH-1:0]];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[PTR_WIDTH-1:0]] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + CNT_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   level <= level + CNT_ONE;
        2'b01:   level <= level - CNT_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else begin
      case ({wr_last, rd_last})
        2'b10:   pkt_count <= pkt_count + CNT_ONE;
        2'b01:   pkt_count <= pkt_count - CNT_ONE;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  assign almost_full  = (level >= AFULL_LVL);
  assign almost_empty = (level <= AEMPTY_LVL);

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// tb/tb_axis_fifo_pkt.sv - scoreboard bench for axis_fifo_pkt, plain (u0) and packet-mode (u1) instances
// A queue per instance models the FIFO contents; flags and levels are derived from it.
module tb_axis_fifo_pkt;

  localparam int DEPTH      = 16;
  localparam int AFULL_THR  = 12;
  localparam int AEMPTY_THR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tvalid     [2];
  logic [7:0] s_tdata      [2];
  logic       s_tlast      [2];
  logic       m_tready     [2];
  logic       s_tready     [2];
  logic       m_tvalid     [2];
  logic [7:0] m_tdata      [2];
  logic       m_tlast      [2];
  logic [4:0] level        [2];
  logic       almost_full  [2];
  logic       almost_empty [2];
  logic [4:0] pkt_count    [2];

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  logic [8:0] exp_q [2][$];
  int         sz;
  int         nl;
  logic       ev;
  logic [8:0] hd;

  always #5 clk = ~clk;

  axis_fifo_pkt #(.PACKET_MODE(0)) u_plain (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]), .s_tdata(s_tdata[0]), .s_tlast(s_tlast[0]),
    .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tdata(m_tdata[0]), .m_tlast(m_tlast[0]),
    .level(level[0]), .almost_full(almost_full[0]), .almost_empty(almost_empty[0]),
    .pkt_count(pkt_count[0])
  );

  axis_fifo_pkt #(.PACKET_MODE(1)) u_pkt (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]), .s_tdata(s_tdata[1]), .s_tlast(s_tlast[1]),
    .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tdata(m_tdata[1]), .m_tlast(m_tlast[1]),
    .level(level[1]), .almost_full(almost_full[1]), .almost_empty(almost_empty[1]),
    .pkt_count(pkt_count[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: compare against the model state left by the previous edge, then
  // account for the handshakes the coming edge will perform.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      sz = exp_q[i].size();
      nl = 0;
      foreach (exp_q[i][k]) if (exp_q[i][k][8]) nl++;
      ev = (sz > 0) && (i == 0 || nl > 0 || sz == DEPTH);
      if (armed) begin
        check($sformatf("u%0d_level", i), 32'(level[i]), 32'(sz));
        check($sformatf("u%0d_pkt_count", i), 32'(pkt_count[i]), 32'(nl));
        check($sformatf("u%0d_s_tready", i), 32'(s_tready[i]), 32'(sz < DEPTH));
        check($sformatf("u%0d_m_tvalid", i), 32'(m_tvalid[i]), 32'(ev));
        check($sformatf("u%0d_almost_full", i), 32'(almost_full[i]), 32'(sz >= AFULL_THR));
        check($sformatf("u%0d_almost_empty", i), 32'(almost_empty[i]), 32'(sz <= AEMPTY_THR));
      end
      if (rst) begin
        exp_q[i].delete();
      end else if (armed) begin
        if (ev && m_tready[i]) begin
          hd = exp_q[i].pop_front();
          check($sformatf("u%0d_m_tdata", i), 32'(m_tdata[i]), 32'(hd[7:0]));
          check($sformatf("u%0d_m_tlast", i), 32'(m_tlast[i]), 32'(hd[8]));
        end
        if (sz < DEPTH && s_tvalid[i]) begin
          exp_q[i].push_back({s_tlast[i], s_tdata[i]});
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic push_word(input int i, input logic [7:0] d, input logic l);
    int n;
    s_tvalid[i] = 1'b1;
    s_tdata[i]  = d;
    s_tlast[i]  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_tready[i]) break;
      n++;
      if (n > 200) begin
        bound_expired($sformatf("u%0d_push_wait", i));
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int i, input int cycles);
    repeat (cycles) begin
      s_tvalid[i] = ($urandom_range(0, 3) != 0);
      s_tdata[i]  = 8'($urandom);
      s_tlast[i]  = ($urandom_range(0, 5) == 0);
      m_tready[i] = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    s_tvalid[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i] = 1'b0;
      s_tdata[i]  = '0;
      s_tlast[i]  = 1'b0;
      m_tready[i] = 1'b0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // Fill the plain FIFO, then try a 17th word.
    for (int k = 0; k < 16; k++) push_word(0, 8'(k), 1'b0);
    s_tvalid[0] = 1'b1;
    s_tdata[0]  = 8'd16;
    repeat (3) begin
      @(negedge clk);
      check("full_s_tready", 32'(s_tready[0]), 32'd0);
      check("full_level", 32'(level[0]), 32'd16);
      check("full_almost_full", 32'(almost_full[0]), 32'd1);
    end
    @(posedge clk);
    #1;
    s_tvalid[0] = 1'b0;
    m_tready[0] = 1'b1;
    idle(20);
    check("drained_m_tvalid", 32'(m_tvalid[0]), 32'd0);

    // 64 back-to-back words with both sides ready.
    for (int k = 0; k < 64; k++) push_word(0, 8'(k + 100), 1'b0);
    idle(4);
    m_tready[0] = 1'b0;

    // Packet mode: 5-word frame at one word per three cycles.
    m_tready[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_word(1, 8'h40 + 8'(k), k == 4);
      if (k < 4) idle(2);
    end
    idle(10);

    // Packet mode: 20-word frame with tlast only on the last word.
    for (int k = 0; k < 20; k++) push_word(1, 8'h80 + 8'(k), k == 19);
    idle(40);
    check("oversize_drained", 32'(level[1]), 32'd0);
    m_tready[1] = 1'b0;

    // Reset with seven words held.
    for (int k = 0; k < 7; k++) push_word(0, 8'(k + 200), k == 3);
    @(negedge clk);
    check("pre_rst_level", 32'(level[0]), 32'd7);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_level", 32'(level[0]), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid[0]), 32'd0);
    check("rst_s_tready", 32'(s_tready[0]), 32'd1);
    check("rst_pkt_count", 32'(pkt_count[0]), 32'd0);
    @(posedge clk);
    #1;
    push_word(0, 8'hA5, 1'b0);
    @(negedge clk);
    check("post_rst_m_tvalid", 32'(m_tvalid[0]), 32'd1);
    check("post_rst_m_tdata", 32'(m_tdata[0]), 32'hA5);
    @(posedge clk);
    #1;

    // Randomised traffic on both instances, then drain.
    fork
      rand_run(0, 400);
      rand_run(1, 400);
    join
    m_tready[0] = 1'b1;
    m_tready[1] = 1'b1;
    idle(40);
    check("final_plain_level", 32'(level[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
